// File: rtl/alu_pkg.sv
// Shared ALU control encodings, arbiter FSM states and the legal-opcode helper
// used by the ALU share arbiter.
package alu_pkg;

  localparam int ALU_CTL_W = 4;

  localparam logic [ALU_CTL_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_CTL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_CTL_W-1:0] ALU_NOR = 4'd12;

  typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_RESP} arb_state_t;

  function automatic logic is_legal_aluctl(input logic [ALU_CTL_W-1:0] ctl);
    return ctl inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter: grants the port that was not granted last on a
// conflict, or port 0 when fixed priority is selected.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic [1:0] grant_onehot,
  output logic       grant_id
);

  always_comb begin
    grant_id = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = fixed ? 1'b0 : ~last;
      default: grant_id = 1'b0;
    endcase
    grant_onehot = (req == 2'b00) ? 2'b00 : (grant_id ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters, one op in flight at a time.
// Define ALU_OPCHECK_EN to flag illegal ALUctl codes through rsp_err.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CTL_W      = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][CTL_W-1:0]  req_ctl,
  input  logic [1:0][DATA_W-1:0] req_a,
  input  logic [1:0][DATA_W-1:0] req_b,
  input  logic [1:0]             req_ztest,
  output logic [CTL_W-1:0]       alu_ctl,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic                   alu_ztest,
  input  logic [DATA_W-1:0]      alu_out,
  input  logic                   alu_zero,
  output logic                   rsp_valid,
  output logic                   rsp_id,
  output logic [DATA_W-1:0]      rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_err,
  input  logic                   rsp_ready
);

  arb_state_t       state;
  logic             last_id;
  logic             cur_id;
  logic             op_err;
  logic [1:0]       grant_onehot;
  logic             grant_id;
  logic [CTL_W-1:0] sel_ctl;
  logic             bad_op;

  rr_arbiter2 u_arb (
    .req          (req_valid),
    .last         (last_id),
    .fixed        (FIXED_PRIO != 0),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id)
  );

  assign req_ready = (state == ARB_IDLE) ? grant_onehot : 2'b00;
  assign sel_ctl   = req_ctl[grant_id];

`ifdef ALU_OPCHECK_EN
  assign bad_op = !is_legal_aluctl(ALU_CTL_W'(sel_ctl));
`else
  assign bad_op = 1'b0;
`endif

  // Illegal ops still run through the ALU as a harmless AND; the response is forced to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_id    <= 1'b1;
      cur_id     <= 1'b0;
      op_err     <= 1'b0;
      alu_ctl    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ztest  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req_valid) begin
            alu_ctl   <= bad_op ? CTL_W'(ALU_AND) : sel_ctl;
            alu_ztest <= bad_op ? 1'b0 : req_ztest[grant_id];
            alu_a     <= req_a[grant_id];
            alu_b     <= req_b[grant_id];
            cur_id    <= grant_id;
            last_id   <= grant_id;
            op_err    <= bad_op;
            state     <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= cur_id;
          rsp_result <= op_err ? '0 : alu_out;
          rsp_zero   <= op_err ? 1'b0 : alu_zero;
          rsp_err    <= op_err;
          state      <= ARB_RESP;
        end
        ARB_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Transaction-level bench for alu_share_arbiter with an ALU model attached;
// honours ALU_OPCHECK_EN when predicting responses.
module tb_alu_share_arbiter;

`ifdef ALU_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][3:0]  req_ctl;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0]       req_ztest;
  logic [3:0]       alu_ctl;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic             alu_ztest;
  logic [31:0]      alu_out;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_id;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic             rsp_err;
  logic             rsp_ready;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: pending op per port and the last granted port
  logic        p_valid[2];
  logic [3:0]  p_ctl[2];
  logic [31:0] p_a[2];
  logic [31:0] p_b[2];
  logic        p_z[2];
  int          last_grant;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_ctl(req_ctl), .req_a(req_a), .req_b(req_b), .req_ztest(req_ztest),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_ztest(alu_ztest),
    .alu_out(alu_out), .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );

  function automatic logic [31:0] alu_ref(input logic [3:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
    case (ctl)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] ctl);
    return !(ctl inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12});
  endfunction

  // The ALU the arbiter drives, modelled behaviourally
  always_comb begin
    alu_out  = alu_ref(alu_ctl, alu_a, alu_b);
    alu_zero = alu_ztest && (alu_out == 32'd0);
  end

  function automatic int predict_grant();
    if (p_valid[0] && p_valid[1]) return (last_grant == 0) ? 1 : 0;
    return p_valid[0] ? 0 : 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_ports();
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = p_valid[i];
      req_ctl[i]   = p_ctl[i];
      req_a[i]     = p_a[i];
      req_b[i]     = p_b[i];
      req_ztest[i] = p_z[i];
    end
  endtask

  task automatic applyStimulus(input int port, input logic [3:0] ctl, input logic [31:0] a,
                               input logic [31:0] b, input logic z);
    p_valid[port] = 1'b1;
    p_ctl[port]   = ctl;
    p_a[port]     = a;
    p_b[port]     = b;
    p_z[port]     = z;
    drive_ports();
  endtask

  task automatic random_op(input int port);
    logic [3:0] ctl_tab[8];
    logic [31:0] a;
    ctl_tab = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd4, 4'd15};
    a = $urandom;
    applyStimulus(port, ctl_tab[$urandom_range(0, 7)], a,
                  ($urandom_range(0, 3) == 0) ? a : 32'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p_valid[i] = 1'b0; p_ctl[i] = '0; p_a[i] = '0; p_b[i] = '0; p_z[i] = 1'b0;
    end
    drive_ports();
    last_grant = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at an IDLE negedge with at least one port pending; returns at the next IDLE negedge
  task automatic serve_one(input int stall, input bit refill);
    int g;
    logic err;
    logic [31:0] res;
    logic zro;
    g   = predict_grant();
    err = OPCHECK && is_illegal(p_ctl[g]);
    res = err ? 32'd0 : alu_ref(p_ctl[g], p_a[g], p_b[g]);
    zro = err ? 1'b0 : (p_z[g] && res == 32'd0);
    #1 checkOutput("req_ready", 32'(req_ready), (g == 0) ? 32'd1 : 32'd2);
    @(posedge clk);
    last_grant = g;
    @(negedge clk);
    checkOutput("alu_ctl", 32'(alu_ctl), err ? 32'd0 : 32'(p_ctl[g]));
    checkOutput("alu_a", alu_a, p_a[g]);
    checkOutput("alu_ztest", 32'(alu_ztest), err ? 32'd0 : 32'(p_z[g]));
    checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("exec_req_ready", 32'(req_ready), 32'd0);
    if (refill) random_op(g);
    else begin
      p_valid[g] = 1'b0;
      drive_ports();
    end
    if (stall > 0) rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_id", 32'(rsp_id), 32'(g));
    checkOutput("rsp_result", rsp_result, res);
    checkOutput("rsp_zero", 32'(rsp_zero), 32'(zro));
    checkOutput("rsp_err", 32'(rsp_err), 32'(err));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_result", rsp_result, res);
      checkOutput("stall_id", 32'(rsp_id), 32'(g));
      checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    do_reset();
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_result", rsp_result, 32'd0);
    checkOutput("reset_alu_ctl", 32'(alu_ctl), 32'd0);
    checkOutput("reset_alu_a", alu_a, 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);

    // Lone port-0 add
    applyStimulus(0, 4'd2, 32'd5, 32'd7, 1'b0);
    serve_one(0, 1'b0);

    // Conflict straight after reset: port 0 first, then port 1
    do_reset();
    applyStimulus(0, 4'd0, 32'hF0, 32'h3C, 1'b0);
    applyStimulus(1, 4'd1, 32'hF0, 32'h0F, 1'b0);
    serve_one(0, 1'b0);
    serve_one(0, 1'b0);

    // Both ports held valid: strict alternation
    do_reset();
    random_op(0);
    random_op(1);
    for (int i = 0; i < 4; i++) serve_one(0, 1'b1);
    p_valid[0] = 1'b0; p_valid[1] = 1'b0; drive_ports();

    // Port 1 subtract with and without the zero test
    applyStimulus(1, 4'd6, 32'd9, 32'd9, 1'b1);
    serve_one(0, 1'b0);
    applyStimulus(1, 4'd6, 32'd9, 32'd9, 1'b0);
    serve_one(0, 1'b0);

    // Backpressure for five cycles
    applyStimulus(0, 4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);
    serve_one(5, 1'b0);

    // Reset while EXEC is in progress
    applyStimulus(0, 4'd2, 32'd1, 32'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_alu_ctl", 32'(alu_ctl), 32'd0);
    do_reset();
    applyStimulus(0, 4'd12, 32'h0, 32'h0, 1'b0);
    applyStimulus(1, 4'd2, 32'd3, 32'd4, 1'b0);
    serve_one(0, 1'b0);
    serve_one(0, 1'b0);

    // Illegal opcode
    applyStimulus(0, 4'd4, 32'd8, 32'd8, 1'b1);
    serve_one(0, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      for (int p = 0; p < 2; p++)
        if (!p_valid[p] && $urandom_range(0, 1) == 1) random_op(p);
      if (!p_valid[0] && !p_valid[1]) random_op(int'($urandom_range(0, 1)));
      serve_one(int'($urandom_range(0, 2)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
